// File: rtl/led_status_pkg.sv
// Shared mode/state types and timing helper for the multi-channel LED status block.
package led_status_pkg;

    typedef enum logic [1:0] {
        LED_OFF  = 2'b00,
        LED_ON   = 2'b01,
        LED_SLOW = 2'b10,
        LED_CODE = 2'b11
    } led_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PULSE_ON  = 2'd1,
        ST_PULSE_OFF = 2'd2,
        ST_GAP       = 2'd3
    } code_st_e;

    function automatic int ms_to_cycles(input int clk_freq_hz);
        return clk_freq_hz / 1000;
    endfunction

endpackage

// File: rtl/led_status_chan.sv
// One LED channel: mode capture, ms timer, slow blink and blink-code sequencer.
module led_status_chan
    import led_status_pkg::*;
#(
    parameter int SLOW_HALF_MS = 500,
    parameter int FAST_HALF_MS = 100,
    parameter int CODE_W       = 3
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              tick_ms,
    input  logic [1:0]        mode_i,
    input  logic [CODE_W-1:0] code_i,
    output logic              led_o
);

    localparam int GAP_MS = 2 * SLOW_HALF_MS;
    localparam int GAP_W  = $clog2(GAP_MS);
    localparam int FAST_W = $clog2(FAST_HALF_MS);
    localparam int TMR_W  = (GAP_W > FAST_W) ? GAP_W : FAST_W;

    localparam logic [TMR_W-1:0] SLOW_LAST = TMR_W'(SLOW_HALF_MS - 1);
    localparam logic [TMR_W-1:0] FAST_LAST = TMR_W'(FAST_HALF_MS - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_MS - 1);

    led_mode_e         mode_q, mode_d;
    code_st_e          st_q, st_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [CODE_W-1:0] cnt_q, cnt_d;
    logic              led_q, led_d;

    led_mode_e mode_in;
    logic      code_nz;

    assign mode_in = led_mode_e'(mode_i);
    assign code_nz = |code_i;

    always_comb begin
        mode_d  = mode_q;
        st_d    = st_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        led_d   = led_q;

        if (mode_in != mode_q) begin
            // A mode change restarts the channel on this very edge; any coincident tick is dropped.
            mode_d  = mode_in;
            timer_d = '0;
            st_d    = ST_IDLE;
            case (mode_in)
                LED_OFF:  led_d = 1'b0;
                LED_ON:   led_d = 1'b1;
                LED_SLOW: led_d = 1'b1;
                default: begin
                    cnt_d = code_i;
                    st_d  = code_nz ? ST_PULSE_ON : ST_GAP;
                    led_d = code_nz;
                end
            endcase
        end else begin
            case (mode_q)
                LED_OFF: led_d = 1'b0;
                LED_ON:  led_d = 1'b1;
                LED_SLOW: begin
                    if (tick_ms) begin
                        if (timer_q == SLOW_LAST) begin
                            led_d   = ~led_q;
                            timer_d = '0;
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                end
                default: begin
                    if (tick_ms) begin
                        timer_d = timer_q + 1'b1;
                        case (st_q)
                            ST_PULSE_ON: begin
                                if (timer_q == FAST_LAST) begin
                                    st_d    = ST_PULSE_OFF;
                                    led_d   = 1'b0;
                                    cnt_d   = cnt_q - 1'b1;
                                    timer_d = '0;
                                end
                            end
                            ST_PULSE_OFF: begin
                                if (timer_q == FAST_LAST) begin
                                    st_d    = (cnt_q != '0) ? ST_PULSE_ON : ST_GAP;
                                    led_d   = (cnt_q != '0);
                                    timer_d = '0;
                                end
                            end
                            ST_GAP: begin
                                // Code is only re-sampled here, so mid-burst changes wait for the gap end.
                                if (timer_q == GAP_LAST) begin
                                    cnt_d   = code_i;
                                    st_d    = code_nz ? ST_PULSE_ON : ST_GAP;
                                    led_d   = code_nz;
                                    timer_d = '0;
                                end
                            end
                            default: begin
                                st_d    = ST_GAP;
                                led_d   = 1'b0;
                                timer_d = '0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= LED_OFF;
            st_q    <= ST_IDLE;
            timer_q <= '0;
            cnt_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            st_q    <= st_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_status_ctrl.sv
// Multi-channel LED status indicator with a shared 1 ms prescaler.
// Define LED_ACTIVE_LOW_EN to drive the LEDs active-low (lit = 0, reset = all ones).
module led_status_ctrl
    import led_status_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 50000000,
    parameter int NUM_CH       = 4,
    parameter int SLOW_HALF_MS = 500,
    parameter int FAST_HALF_MS = 100,
    parameter int CODE_W       = 3
) (
    input  logic                     clk_50m,
    input  logic                     rst_n,
    input  logic [2*NUM_CH-1:0]      mode_i,
    input  logic [CODE_W*NUM_CH-1:0] code_i,
    output logic [NUM_CH-1:0]        led
);

    localparam int DIV   = ms_to_cycles(CLK_FREQ_HZ);
    localparam int PRE_W = $clog2(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0]  presc_q, presc_d;
    logic              tick_ms;
    logic [NUM_CH-1:0] led_raw;

    // Free-running: mode changes never touch the prescaler phase.
    always_comb begin
        tick_ms = (presc_q == PRE_LAST);
        presc_d = tick_ms ? '0 : presc_q + 1'b1;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        led_status_chan #(
            .SLOW_HALF_MS (SLOW_HALF_MS),
            .FAST_HALF_MS (FAST_HALF_MS),
            .CODE_W       (CODE_W)
        ) u_chan (
            .clk_50m (clk_50m),
            .rst_n   (rst_n),
            .tick_ms (tick_ms),
            .mode_i  (mode_i[2*k +: 2]),
            .code_i  (code_i[CODE_W*k +: CODE_W]),
            .led_o   (led_raw[k])
        );
    end

`ifdef LED_ACTIVE_LOW_EN
    assign led = ~led_raw;
`else
    assign led = led_raw;
`endif

endmodule

// File: tb/tb_led_status_ctrl.sv
// Self-checking bench for led_status_ctrl: vector table, timed corner sequences, random run vs. timeline model.
module tb_led_status_ctrl;

    localparam int CLK_HZ = 10000;
    localparam int DIV    = 10;
    localparam int S      = 5;
    localparam int F      = 2;
    localparam int NCH    = 2;
    localparam int CW     = 3;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [1:0] POL = 2'b11;
`else
    localparam logic [1:0] POL = 2'b00;
`endif

    logic       clk_50m = 1'b0;
    logic       rst_n;
    logic [3:0] mode_i;
    logic [5:0] code_i;
    logic [1:0] led;

    int total = 0;
    int bad   = 0;

    // Timeline model: ticks elapsed since the last (re)start of each channel.
    int ecount;
    int m_mode[NCH];
    int m_n[NCH];
    int m_c[NCH];

    led_status_ctrl #(
        .CLK_FREQ_HZ  (CLK_HZ),
        .NUM_CH       (NCH),
        .SLOW_HALF_MS (S),
        .FAST_HALF_MS (F),
        .CODE_W       (CW)
    ) dut (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .mode_i  (mode_i),
        .code_i  (code_i),
        .led     (led)
    );

    always #5 clk_50m = ~clk_50m;

    function automatic logic model_led(input int ch);
        case (m_mode[ch])
            0: return 1'b0;
            1: return 1'b1;
            2: return ((m_n[ch] / S) % 2) == 0;
            default: begin
                if (m_n[ch] < m_c[ch] * 2 * F) return (m_n[ch] % (2 * F)) < F;
                return 1'b0;
            end
        endcase
    endfunction

    function automatic logic [1:0] model_vec();
        return {model_led(1), model_led(0)};
    endfunction

    function automatic logic lvl(input int i);
        return led[i] ^ POL[i];
    endfunction

    task automatic model_edge();
        bit tick;
        if (!rst_n) begin
            ecount = 0;
            for (int c = 0; c < NCH; c++) begin
                m_mode[c] = 0; m_n[c] = 0; m_c[c] = 0;
            end
            return;
        end
        ecount++;
        tick = (ecount % DIV) == 0;
        for (int c = 0; c < NCH; c++) begin
            int mi, ci;
            mi = int'(mode_i[2*c +: 2]);
            ci = int'(code_i[CW*c +: CW]);
            if (mi != m_mode[c]) begin
                m_mode[c] = mi; m_n[c] = 0; m_c[c] = ci;
            end else if (tick) begin
                m_n[c]++;
                if (m_mode[c] == 3 && m_n[c] == m_c[c] * 2 * F + 2 * S) begin
                    m_n[c] = 0; m_c[c] = ci;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk_50m);
        model_edge();
        @(negedge clk_50m);
        check("model", 32'(led ^ POL), 32'(model_vec()));
    endtask

    task automatic measure(input int idx, input int limit, output int n);
        logic prev;
        prev = led[idx];
        n = 0;
        while (n < limit) begin
            step();
            n++;
            if (led[idx] != prev) return;
        end
        n = -1;
    endtask

    task automatic interval(input string name, input int lo, input int hi);
        int n;
        measure(0, hi + 10, n);
        check_rng(name, n, lo, hi);
    endtask

    task automatic set_in(input logic [3:0] m, input logic [5:0] c);
        mode_i = m;
        code_i = c;
    endtask

    typedef struct {
        logic [3:0] mode;
        logic [5:0] code;
        logic [1:0] exp;
    } vec_t;

    vec_t vt[9];

    initial begin
        int n;
        bit dark;

        vt[0] = '{4'b0000, 6'b000_000, 2'b00};
        vt[1] = '{4'b0101, 6'b000_000, 2'b11};
        vt[2] = '{4'b0100, 6'b000_000, 2'b10};
        vt[3] = '{4'b1010, 6'b000_000, 2'b11};
        vt[4] = '{4'b1111, 6'b000_011, 2'b01};
        vt[5] = '{4'b0011, 6'b000_000, 2'b01};
        vt[6] = '{4'b0000, 6'b000_000, 2'b00};
        vt[7] = '{4'b1101, 6'b101_000, 2'b11};
        vt[8] = '{4'b0111, 6'b000_000, 2'b10};

        rst_n = 1'b0;
        set_in(4'b0000, 6'b0);
        repeat (3) step();
        check("reset_value", 32'(led), 32'(POL));
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            set_in(vt[i].mode, vt[i].code);
            step();
            check($sformatf("vec%0d", i), 32'(led ^ POL), 32'(vt[i].exp));
        end

        // Slow blink on ch0, ch1 off.
        set_in(4'b0000, 6'b0); step();
        set_in(4'b0010, 6'b0); step();
        check("slow_entry", 32'(lvl(0)), 32'd1);
        interval("slow_first", 41, 50);
        for (int i = 0; i < 3; i++) interval("slow_half", 50, 50);
        check("slow_ch1_off", 32'(lvl(1)), 32'd0);

        // Code 3: three pulses then the gap, then repeat.
        set_in(4'b0000, 6'b0); step();
        set_in(4'b0011, 6'd3); step();
        check("c3_entry", 32'(lvl(0)), 32'd1);
        interval("c3_hi_first", 11, 20);
        interval("c3_lo", 20, 20);
        interval("c3_hi", 20, 20);
        interval("c3_lo", 20, 20);
        interval("c3_hi", 20, 20);
        interval("c3_lo_gap", 120, 120);
        interval("c3_hi_repeat", 20, 20);

        // Code changed 3 -> 1 during the second pulse.
        set_in(4'b0000, 6'b0); step();
        set_in(4'b0011, 6'd3); step();
        interval("chg_hi_first", 11, 20);
        interval("chg_lo", 20, 20);
        repeat (5) step();
        code_i = 6'd1;
        interval("chg_hi_rest", 15, 15);
        interval("chg_lo", 20, 20);
        interval("chg_hi3", 20, 20);
        interval("chg_lo_gap", 120, 120);
        interval("chg_hi_new", 20, 20);
        interval("chg_lo_gap_new", 120, 120);
        interval("chg_hi_new2", 20, 20);

        // Code 0 stays dark, then picks up a new code at a gap end.
        set_in(4'b0000, 6'b0); step();
        set_in(4'b0011, 6'd0); step();
        dark = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (lvl(0) != 1'b0) dark = 1'b0;
        end
        check("code0_dark", 32'(dark), 32'd1);
        code_i = 6'd2;
        measure(0, 101, n);
        check_rng("code0_wake", n, 1, 100);
        check("code0_wake_lvl", 32'(lvl(0)), 32'd1);
        interval("c2_hi", 20, 20);
        interval("c2_lo", 20, 20);
        interval("c2_hi", 20, 20);
        interval("c2_lo_gap", 120, 120);

        // SLOW -> ON mid-low, then ON -> SLOW.
        set_in(4'b0000, 6'b0); step();
        set_in(4'b0010, 6'b0); step();
        interval("so_first", 41, 50);
        repeat (10) step();
        check("so_low", 32'(lvl(0)), 32'd0);
        mode_i = 4'b0001; step();
        check("so_on", 32'(lvl(0)), 32'd1);
        repeat (5) step();
        mode_i = 4'b0010; step();
        check("os_entry", 32'(lvl(0)), 32'd1);
        interval("os_first", 41, 50);
        check("os_toggled", 32'(lvl(0)), 32'd0);

        // Random modes and codes against the model.
        for (int r = 0; r < 30; r++) begin
            set_in(4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)));
            repeat ($urandom_range(5, 250)) step();
        end

        // Asynchronous reset mid-blink, release straight into ON/ON.
        set_in(4'b0011, 6'd3);
        repeat (30) step();
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'(led), 32'(POL));
        step();
        step();
        rst_n = 1'b1;
        set_in(4'b0101, 6'b0);
        step();
        check("reset_release_on", 32'(led ^ POL), 32'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
